// File: rtl/bm_pkg.sv
// Shared types and derived geometry for the block-match engine.
package bm_pkg;
    localparam int RD_PORT_W    = 8;
    localparam int BIT_FRAME_W  = 960;
    localparam int BLOCK_SIZE   = 16;
    localparam int SEARCH_BLK_W = 64;
    localparam int SEARCH_BLK_H = 32;

    localparam int FRAME_ADDR_W = BIT_FRAME_W / RD_PORT_W;
    localparam int BLK_WORDS    = BLOCK_SIZE / RD_PORT_W;
    localparam int SRCH_WORDS   = SEARCH_BLK_W / RD_PORT_W;
    localparam int N_DX         = SEARCH_BLK_W - BLOCK_SIZE + 1;
    localparam int N_DY         = SEARCH_BLK_H - BLOCK_SIZE + 1;
    localparam int COST_W       = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADBLK,
        ST_CLRACC,
        ST_LOADROW,
        ST_ACCUM,
        ST_SCAN,
        ST_REPORT
    } bm_state_e;
endpackage

// File: rtl/block_match_engine_if.sv
// Start/done handshake, memory read port and result bus of one block-match engine.
interface block_match_engine_if;
    import bm_pkg::*;

    logic                 bm_start;
    logic [15:0]          blk_addr;
    logic [15:0]          srch_addr;
    logic [15:0]          blk_index;
    logic                 bm_done;
    logic [15:0]          rd_addr;
    logic                 rd_en;
    logic [RD_PORT_W-1:0] rd_data;
    logic                 result_valid;
    logic [15:0]          result_index;
    logic [5:0]           best_dx;
    logic [4:0]           best_dy;
    logic [COST_W-1:0]    best_cost;

    modport slave (
        input  bm_start, blk_addr, srch_addr, blk_index, rd_data,
        output bm_done, rd_addr, rd_en, result_valid, result_index, best_dx, best_dy, best_cost
    );

    modport master (
        output bm_start, blk_addr, srch_addr, blk_index, rd_data,
        input  bm_done, rd_addr, rd_en, result_valid, result_index, best_dx, best_dy, best_cost
    );
endinterface

// File: rtl/bm_popcount16.sv
// Hamming distance of two 16-pixel binary rows.
module bm_popcount16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [4:0]  cnt_o
);
    logic [15:0] diff;

    always_comb begin
        diff  = a_i ^ b_i;
        cnt_o = '0;
        for (int i = 0; i < 16; i++) cnt_o = cnt_o + {4'd0, diff[i]};
    end
endmodule

// File: rtl/block_match_engine.sv
// Block-match engine: loads a 16x16 binary block, Hamming-scans it over a 64x32 window.
// Latency: 32 + 17*(1 + 16*(8+1+1) + 49) = 3602 edges from the accepting edge to the edge raising result_valid.
module block_match_engine
    import bm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    block_match_engine_if.slave bm
);
    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

    bm_state_e                            state_q, state_d;
    logic [15:0]                          blk_addr_q, srch_addr_q, index_q;
    logic [3:0]                           r_q, w_q;
    logic [4:0]                           dy_q;
    logic [5:0]                           dx_q;
    logic [5:0]                           best_dx_q;
    logic [4:0]                           best_dy_q;
    logic [COST_W-1:0]                    best_cost_q;
    logic                                 rd_vld_q, rd_blk_q;
    logic [3:0]                           rd_row_q;
    logic [2:0]                           rd_word_q;
    logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0] blk_rows_q;
    logic [SEARCH_BLK_W-1:0]              srow_q;
    logic [N_DX-1:0][COST_W-1:0]          acc_q;
    logic [N_DX-1:0][CNT_W-1:0]           pc;
    logic                                 rd_en, result_valid;
    logic [15:0]                          base, rd_addr;
    logic [4:0]                           row_sel;
    logic [14:0]                          row_off;

    for (genvar g = 0; g < N_DX; g++) begin : g_pc
        bm_popcount16 u_pc (
            .a_i  (blk_rows_q[r_q]),
            .b_i  (srow_q[g +: BLOCK_SIZE]),
            .cnt_o(pc[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        result_valid = 1'b0;
        base         = blk_addr_q;
        row_sel      = {1'b0, r_q};
        case (state_q)
            ST_IDLE:    if (bm.bm_start) state_d = ST_LOADBLK;
            ST_LOADBLK: begin
                rd_en = 1'b1;
                if (r_q == 4'(BLOCK_SIZE - 1) && w_q == 4'(BLK_WORDS - 1)) state_d = ST_CLRACC;
            end
            ST_CLRACC:  state_d = ST_LOADROW;
            // One extra cycle after the last word so srow_q is complete before ACCUM
            ST_LOADROW: begin
                base    = srch_addr_q;
                row_sel = dy_q + {1'b0, r_q};
                rd_en   = (w_q < 4'(SRCH_WORDS));
                if (w_q == 4'(SRCH_WORDS)) state_d = ST_ACCUM;
            end
            ST_ACCUM:   state_d = (r_q == 4'(BLOCK_SIZE - 1)) ? ST_SCAN : ST_LOADROW;
            ST_SCAN:    if (dx_q == 6'(N_DX - 1)) state_d = (dy_q == 5'(N_DY - 1)) ? ST_REPORT : ST_CLRACC;
            ST_REPORT: begin
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
        row_off = 15'(row_sel) * 15'(FRAME_ADDR_W);
        rd_addr = {base[15], base[14:0] + row_off + {11'd0, w_q}};
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            blk_addr_q  <= '0;
            srch_addr_q <= '0;
            index_q     <= '0;
            r_q         <= '0;
            w_q         <= '0;
            dy_q        <= '0;
            dx_q        <= '0;
            best_dx_q   <= '0;
            best_dy_q   <= '0;
            best_cost_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_blk_q    <= 1'b0;
            rd_row_q    <= '0;
            rd_word_q   <= '0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_blk_q  <= (state_q == ST_LOADBLK);
            rd_row_q  <= r_q;
            rd_word_q <= w_q[2:0];
            case (state_q)
                ST_IDLE: if (bm.bm_start) begin
                    blk_addr_q  <= bm.blk_addr;
                    srch_addr_q <= bm.srch_addr;
                    index_q     <= bm.blk_index;
                    r_q         <= '0;
                    w_q         <= '0;
                    dy_q        <= '0;
                    dx_q        <= '0;
                    best_dx_q   <= '0;
                    best_dy_q   <= '0;
                    best_cost_q <= '1;
                end
                ST_LOADBLK: begin
                    if (w_q == 4'(BLK_WORDS - 1)) begin
                        w_q <= '0;
                        r_q <= r_q + 4'd1;
                    end else begin
                        w_q <= w_q + 4'd1;
                    end
                end
                ST_CLRACC: begin
                    r_q <= '0;
                    w_q <= '0;
                end
                ST_LOADROW: w_q <= w_q + 4'd1;
                ST_ACCUM: begin
                    w_q  <= '0;
                    r_q  <= r_q + 4'd1;
                    dx_q <= '0;
                end
                // Strict compare keeps the earliest (dy, dx) on ties
                ST_SCAN: begin
                    if (acc_q[dx_q] < best_cost_q) begin
                        best_cost_q <= acc_q[dx_q];
                        best_dx_q   <= dx_q;
                        best_dy_q   <= dy_q;
                    end
                    if (dx_q == 6'(N_DX - 1)) begin
                        dx_q <= '0;
                        dy_q <= dy_q + 5'd1;
                    end else begin
                        dx_q <= dx_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_q) begin
            if (rd_blk_q) blk_rows_q[rd_row_q][rd_word_q * RD_PORT_W +: RD_PORT_W] <= bm.rd_data;
            else          srow_q[rd_word_q * RD_PORT_W +: RD_PORT_W] <= bm.rd_data;
        end
        if (state_q == ST_CLRACC) begin
            acc_q <= '0;
        end else if (state_q == ST_ACCUM) begin
            for (int g = 0; g < N_DX; g++) acc_q[g] <= acc_q[g] + COST_W'(pc[g]);
        end
    end

    assign bm.bm_done      = (state_q == ST_IDLE);
    assign bm.rd_en        = rd_en;
    assign bm.rd_addr      = rd_addr;
    assign bm.result_valid = result_valid;
    assign bm.result_index = index_q;
    assign bm.best_dx      = best_dx_q;
    assign bm.best_dy      = best_dy_q;
    assign bm.best_cost    = best_cost_q;
endmodule

// File: tb/tb_block_match_engine.sv
// Self-checking bench for block_match_engine: vector table plus reset/handshake sequences.
module tb_block_match_engine;
    localparam int FAW = 120;
    localparam int NDX = 49;
    localparam int NDY = 17;

    typedef struct {
        logic [15:0] blk;
        logic [15:0] srch;
        logic [15:0] idx;
        int          fill;   // 0 zero, 1 random, 2 random+exact plant, 3 ones block/zero window, 4 random+noisy plant
        int          pdx;
        int          pdy;
        bit          use_model;
        int          edx;
        int          edy;
        int          ecost;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    block_match_engine_if bm();
    block_match_engine dut (.clk(clk), .reset(reset), .bm(bm));

    logic [7:0]  mem [0:65535];
    logic [15:0] alog[$];
    int npulse = 0;
    int tests  = 0;
    int fails  = 0;
    int lat0   = -1;

    always @(posedge clk) begin
        if (bm.rd_en) begin
            bm.rd_data <= mem[bm.rd_addr];
            alog.push_back(bm.rd_addr);
        end
        if (bm.result_valid) npulse++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] waddr(input logic [15:0] base, input int row, input int w);
        logic [14:0] lo;
        lo = base[14:0] + 15'(row * FAW + w);
        return {base[15], lo};
    endfunction

    function automatic bit getpix(input logic [15:0] base, input int row, input int col);
        logic [7:0] b;
        b = mem[waddr(base, row, col / 8)];
        return b[col % 8];
    endfunction

    task automatic setpix(input logic [15:0] base, input int row, input int col, input bit v);
        logic [15:0] a;
        logic [7:0]  b;
        a = waddr(base, row, col / 8);
        b = mem[a];
        b[col % 8] = v;
        mem[a] = b;
    endtask

    task automatic prep_mem(input vec_t v);
        bit p;
        for (int i = 0; i < 65536; i++)
            mem[i] = (v.fill == 0 || v.fill == 3) ? 8'h00 : 8'($urandom);
        if (v.fill == 3)
            for (int r = 0; r < 16; r++)
                for (int w = 0; w < 2; w++) mem[waddr(v.blk, r, w)] = 8'hFF;
        if (v.fill == 2 || v.fill == 4)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    p = getpix(v.blk, r, c);
                    if (v.fill == 4 && $urandom_range(15) == 0) p = ~p;
                    setpix(v.srch, v.pdy + r, v.pdx + c, p);
                end
    endtask

    // Exhaustive search over all offsets; earliest (dy, dx) wins ties
    task automatic model(input logic [15:0] blk, input logic [15:0] srch,
                         output int bdx, output int bdy, output int bc);
        bit b [16][16];
        bit s [32][64];
        int cost;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) b[r][c] = getpix(blk, r, c);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++) s[r][c] = getpix(srch, r, c);
        bc = 511; bdx = 0; bdy = 0;
        for (int dy = 0; dy < NDY; dy++)
            for (int dx = 0; dx < NDX; dx++) begin
                cost = 0;
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) cost += int'(b[r][c] ^ s[dy + r][dx + c]);
                if (cost < bc) begin
                    bc = cost; bdx = dx; bdy = dy;
                end
            end
    endtask

    task automatic do_run(input string tag, input vec_t v, input int hold);
        int edx, edy, ec, lat, p0, k, nbad, n15, e15;
        logic [15:0] exq[$];
        if (v.use_model) model(v.blk, v.srch, edx, edy, ec);
        else begin
            edx = v.edx; edy = v.edy; ec = v.ecost;
        end
        for (int r = 0; r < 16; r++)
            for (int w = 0; w < 2; w++) exq.push_back(waddr(v.blk, r, w));
        for (int dy = 0; dy < NDY; dy++)
            for (int r = 0; r < 16; r++)
                for (int w = 0; w < 8; w++) exq.push_back(waddr(v.srch, dy + r, w));

        k = 0;
        while (bm.bm_done !== 1'b1 && k < 100) begin
            @(negedge clk); k++;
        end
        chk({tag, "_idle"}, 32'(bm.bm_done), 1);
        alog.delete();
        p0 = npulse;
        bm.blk_addr = v.blk; bm.srch_addr = v.srch; bm.blk_index = v.idx;
        bm.bm_start = 1'b1;
        @(negedge clk);
        chk({tag, "_done_fall"}, 32'(bm.bm_done), 0);
        lat = 1;
        if (hold <= 1) bm.bm_start = 1'b0;
        while (bm.result_valid !== 1'b1 && lat < 8000) begin
            @(negedge clk); lat++;
            if (lat >= hold) bm.bm_start = 1'b0;
        end
        bm.bm_start = 1'b0;
        chk({tag, "_rv_seen"}, 32'(bm.result_valid), 1);
        chk({tag, "_index"}, 32'(bm.result_index), 32'(v.idx));
        chk({tag, "_dx"}, 32'(bm.best_dx), edx);
        chk({tag, "_dy"}, 32'(bm.best_dy), edy);
        chk({tag, "_cost"}, 32'(bm.best_cost), ec);
        if (lat0 < 0) lat0 = lat;
        else chk({tag, "_latency"}, lat, lat0);
        @(negedge clk);
        chk({tag, "_rv_1cyc"}, 32'(bm.result_valid), 0);
        chk({tag, "_done_rise"}, 32'(bm.bm_done), 1);
        chk({tag, "_pulses"}, npulse - p0, 1);
        chk({tag, "_addr_cnt"}, alog.size(), exq.size());
        nbad = 0; n15 = 0;
        for (int i = 0; i < alog.size(); i++) begin
            if (i >= exq.size() || alog[i] !== exq[i]) begin
                if (nbad == 0) $display("  %s first addr diff at %0d: %h", tag, i, alog[i]);
                nbad++;
            end
            if (alog[i][15]) n15++;
        end
        chk({tag, "_addr_seq"}, nbad, 0);
        e15 = 32 * int'(v.blk[15]) + NDY * 16 * 8 * int'(v.srch[15]);
        chk({tag, "_bit15"}, n15, e15);
    endtask

    vec_t vecs [7];

    initial begin
        int zr, k, rvs, p0;
        bm.bm_start = 1'b0; bm.blk_addr = '0; bm.srch_addr = '0; bm.blk_index = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(bm.bm_done), 1);
        chk("rst_rd_en", 32'(bm.rd_en), 0);
        chk("rst_rv", 32'(bm.result_valid), 0);
        chk("rst_dx", 32'(bm.best_dx), 0);
        chk("rst_dy", 32'(bm.best_dy), 0);
        chk("rst_cost", 32'(bm.best_cost), 0);
        chk("rst_index", 32'(bm.result_index), 0);
        reset = 1'b1;
        @(negedge clk);

        vecs[0] = '{16'h0100, 16'h0000, 16'h1234, 2, 20, 8, 1'b0, 20, 8, 0};
        vecs[1] = '{16'h0100, 16'h0000, 16'hBEEF, 0, 0, 0, 1'b0, 0, 0, 0};
        vecs[2] = '{16'h0100, 16'h0000, 16'h0042, 3, 0, 0, 1'b0, 0, 0, 256};
        vecs[3] = '{16'h8100, 16'h8000, 16'($urandom), 1, 0, 0, 1'b1, -1, -1, -1};
        vecs[4] = '{16'h7FF0, 16'hFF00, 16'($urandom), 1, 0, 0, 1'b1, -1, -1, -1};
        vecs[5] = '{16'($urandom), 16'($urandom), 16'($urandom), 4,
                    int'($urandom_range(48)), int'($urandom_range(16)), 1'b1, -1, -1, -1};
        vecs[6] = '{16'($urandom), 16'($urandom), 16'($urandom), 4,
                    int'($urandom_range(48)), int'($urandom_range(16)), 1'b1, -1, -1, -1};

        for (int i = 0; i < 7; i++) begin
            prep_mem(vecs[i]);
            do_run($sformatf("v%0d", i), vecs[i], 1);
        end

        prep_mem(vecs[0]);
        do_run("hold5", vecs[0], 5);

        // Abort a run once it is scanning (long stretch without reads)
        prep_mem(vecs[3]);
        bm.blk_addr = vecs[3].blk; bm.srch_addr = vecs[3].srch; bm.blk_index = vecs[3].idx;
        bm.bm_start = 1'b1;
        @(negedge clk);
        bm.bm_start = 1'b0;
        zr = 0; k = 0;
        while (zr < 5 && k < 2000) begin
            @(negedge clk); k++;
            zr = bm.rd_en ? 0 : zr + 1;
        end
        chk("abort_scan_reached", zr, 5);
        p0 = npulse;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_done", 32'(bm.bm_done), 1);
        chk("abort_rd_en", 32'(bm.rd_en), 0);
        chk("abort_rv", 32'(bm.result_valid), 0);
        chk("abort_cost", 32'(bm.best_cost), 0);
        rvs = 0;
        repeat (20) begin
            @(negedge clk);
            if (bm.result_valid) rvs++;
        end
        chk("abort_no_rv", rvs + npulse - p0, 0);
        prep_mem(vecs[5]);
        do_run("post_abort", vecs[5], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
